// File: rtl/bcd_counter_ndigit.sv
// Multi-digit up/down decade counter with parallel load, enable, terminal count and wrap pulse.
// Define BCD_CNT_SAT_EN to build the saturating variant (full-count steps hold instead of wrapping).
module bcd_counter_ndigit #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_MAX = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sta,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] num,
    output logic                cop,
    output logic                wrap
);

    localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

    // chain[k] = every digit below k is at carry/borrow; chain[0] is always set
    logic [DIGITS:0]       chain;
    logic [4*DIGITS-1:0]   num_step;

    assign chain[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] d;
        logic [3:0] d_next;
        logic       pass;

        assign d = num[4*k +: 4];

        always_comb begin
            d_next = d;
            pass   = 1'b0;
            if (chain[k]) begin
                if (!sta) begin
                    if (d >= DMAX) begin
                        d_next = 4'd0;
                        pass   = 1'b1;
                    end else begin
                        d_next = d + 4'd1;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d_next = DMAX;
                        pass   = 1'b1;
                    end else if (d > DMAX) begin
                        d_next = DMAX;
                    end else begin
                        d_next = d - 4'd1;
                    end
                end
            end
        end

        assign chain[k+1]         = pass;
        assign num_step[4*k +: 4] = d_next;
    end

    // A carry out of the top digit happens exactly when every digit is at its terminal value
    assign cop = chain[DIGITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            num  <= load_val;
            wrap <= 1'b0;
        end else if (en) begin
`ifdef BCD_CNT_SAT_EN
            if (!cop) begin
                num <= num_step;
            end
            wrap <= 1'b0;
`else
            num  <= num_step;
            wrap <= cop;
`endif
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
